// File: rtl/mul_wb_pipe.sv
// Elastic multiplier-to-writeback register chain: valid/ready handshake,
// bubble collapsing, global flush and a registered occupancy count.
module mul_wb_pipe #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4,
  parameter int EXC_W  = 3,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_mul_out,
  input  logic [IDX_W-1:0]  in_complete_idx,
  input  logic [EXC_W-1:0]  in_exception_vector,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mul_out,
  output logic [IDX_W-1:0]  out_complete_idx,
  output logic [EXC_W-1:0]  out_exception_vector,
  output logic [CNT_W-1:0]  occupancy
);

  logic [DEPTH-1:0]  w_v;
  logic [DEPTH-1:0]  w_adv;
  logic              w_accept;
  logic              w_fire;
  logic [DATA_W-1:0] w_data [DEPTH];
  logic [IDX_W-1:0]  w_idx  [DEPTH];
  logic [EXC_W-1:0]  w_exc  [DEPTH];
  logic [CNT_W-1:0]  r_occ;

  // Advance is resolved from the head backwards so that a stage can move into
  // a slot that is being vacated in the same cycle. Flush freezes every move.
  always_comb begin
    logic [DEPTH-1:0] l_adv;
    l_adv = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (s == DEPTH - 1) begin
        l_adv[s] = w_v[s] & out_ready & !flush;
      end else begin
        l_adv[s] = w_v[s] & (!w_v[s+1] | l_adv[s+1]) & !flush;
      end
    end
    w_adv = l_adv;
  end

  assign in_ready = (!w_v[0] | w_adv[0]) & !flush;
  assign w_accept = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic              r_v;
      logic [DATA_W-1:0] r_data;
      logic [IDX_W-1:0]  r_idx;
      logic [EXC_W-1:0]  r_exc;
      logic              w_load;
      logic [DATA_W-1:0] w_src_data;
      logic [IDX_W-1:0]  w_src_idx;
      logic [EXC_W-1:0]  w_src_exc;

      if (gi == 0) begin : g_entry
        assign w_load     = w_accept;
        assign w_src_data = in_mul_out;
        assign w_src_idx  = in_complete_idx;
        assign w_src_exc  = in_exception_vector;
      end else begin : g_link
        assign w_load     = w_adv[gi-1];
        assign w_src_data = w_data[gi-1];
        assign w_src_idx  = w_idx[gi-1];
        assign w_src_exc  = w_exc[gi-1];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_v    <= 1'b0;
          r_data <= '0;
          r_idx  <= '0;
          r_exc  <= '0;
        end else begin
          if (flush) begin
            r_v <= 1'b0;
          end else if (w_load) begin
            r_v <= 1'b1;
          end else if (w_adv[gi]) begin
            r_v <= 1'b0;
          end
          // Payload only changes on a capture; w_load is already flush-masked.
          if (w_load) begin
            r_data <= w_src_data;
            r_idx  <= w_src_idx;
            r_exc  <= w_src_exc;
          end
        end
      end

      assign w_v[gi]    = r_v;
      assign w_data[gi] = r_data;
      assign w_idx[gi]  = r_idx;
      assign w_exc[gi]  = r_exc;
    end
  endgenerate

  assign out_valid            = w_v[DEPTH-1] & !flush;
  assign out_mul_out          = w_data[DEPTH-1];
  assign out_complete_idx     = w_idx[DEPTH-1];
  assign out_exception_vector = w_exc[DEPTH-1];
  assign w_fire               = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_fire})
        2'b10:   r_occ <= r_occ + CNT_W'(1);
        2'b01:   r_occ <= r_occ - CNT_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occupancy = r_occ;

endmodule

// File: tb/tb_mul_wb_pipe.sv
// Bench for mul_wb_pipe: DEPTH=2 and DEPTH=3 instances share one stimulus
// stream and are compared every cycle against a slot-position queue model.
module tb_mul_wb_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_mul_out;
  logic [3:0]  in_complete_idx;
  logic [2:0]  in_exception_vector;

  logic        ir2, ov2, ir3, ov3;
  logic [31:0] od2, od3;
  logic [3:0]  oi2, oi3;
  logic [2:0]  oe2, oe3;
  logic [1:0]  occ2, occ3;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: per instance k (0 -> DEPTH 2, 1 -> DEPTH 3), entries oldest-first
  // with their stage position, plus the last payload that reached the head.
  int          m_cnt [2];
  int          m_pos [2][4];
  logic [31:0] m_dat [2][4];
  logic [3:0]  m_idx [2][4];
  logic [2:0]  m_exc [2][4];
  logic [31:0] h_dat [2];
  logic [3:0]  h_idx [2];
  logic [2:0]  h_exc [2];

  always #5 clk = ~clk;

  mul_wb_pipe #(.DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir2),
    .in_mul_out(in_mul_out), .in_complete_idx(in_complete_idx),
    .in_exception_vector(in_exception_vector),
    .out_valid(ov2), .out_ready(out_ready),
    .out_mul_out(od2), .out_complete_idx(oi2),
    .out_exception_vector(oe2), .occupancy(occ2)
  );

  mul_wb_pipe #(.DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir3),
    .in_mul_out(in_mul_out), .in_complete_idx(in_complete_idx),
    .in_exception_vector(in_exception_vector),
    .out_valid(ov3), .out_ready(out_ready),
    .out_mul_out(od3), .out_complete_idx(oi3),
    .out_exception_vector(oe3), .occupancy(occ3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      h_dat[k] = '0;
      h_idx[k] = '0;
      h_exc[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    int d, n, base;
    int np [4];
    bit fire, ir_e, ov_e;
    logic        ov, ir;
    logic [31:0] od;
    logic [3:0]  oi;
    logic [2:0]  oe;
    logic [1:0]  oc;
    d = (k == 0) ? 2 : 3;
    if (k == 0) {ov, ir, od, oi, oe, oc} = {ov2, ir2, od2, oi2, oe2, occ2};
    else        {ov, ir, od, oi, oe, oc} = {ov3, ir3, od3, oi3, oe3, occ3};

    ov_e = !flush && m_cnt[k] > 0 && m_pos[k][0] == d - 1;
    fire = ov_e && out_ready;
    base = fire ? 1 : 0;
    // Each surviving entry steps forward if the slot ahead ends up free.
    n = 0;
    for (int i = base; i < m_cnt[k]; i++) begin
      int lim;
      lim = (n == 0) ? d : np[n-1];
      np[n] = (m_pos[k][i] + 1 < lim) ? m_pos[k][i] + 1 : m_pos[k][i];
      n++;
    end
    ir_e = !flush && (n == 0 || np[n-1] > 0);

    check($sformatf("d%0d out_valid", d), ov, ov_e);
    check($sformatf("d%0d in_ready", d), ir, ir_e);
    check($sformatf("d%0d occupancy", d), oc, m_cnt[k]);
    check($sformatf("d%0d out_mul_out", d), od, h_dat[k]);
    check($sformatf("d%0d out_idx", d), oi, h_idx[k]);
    check($sformatf("d%0d out_exc", d), oe, h_exc[k]);

    if (reset) begin
      m_cnt[k] = 0;
      h_dat[k] = '0;
      h_idx[k] = '0;
      h_exc[k] = '0;
    end else if (flush) begin
      m_cnt[k] = 0;
    end else begin
      for (int j = 0; j < n; j++) begin
        if (np[j] == d - 1 && m_pos[k][j+base] != d - 1) begin
          h_dat[k] = m_dat[k][j+base];
          h_idx[k] = m_idx[k][j+base];
          h_exc[k] = m_exc[k][j+base];
        end
        m_pos[k][j] = np[j];
        m_dat[k][j] = m_dat[k][j+base];
        m_idx[k][j] = m_idx[k][j+base];
        m_exc[k][j] = m_exc[k][j+base];
      end
      m_cnt[k] = n;
      if (in_valid && ir_e) begin
        m_pos[k][n] = 0;
        m_dat[k][n] = in_mul_out;
        m_idx[k][n] = in_complete_idx;
        m_exc[k][n] = in_exception_vector;
        m_cnt[k] = n + 1;
      end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] dat, input logic [3:0] idx,
                       input logic [2:0] exc, input bit ordy, input bit fl, input bit rst);
    in_valid            = v;
    in_mul_out          = dat;
    in_complete_idx     = idx;
    in_exception_vector = exc;
    out_ready           = ordy;
    flush               = fl;
    reset               = rst;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 0; in_mul_out = '0; in_complete_idx = '0; in_exception_vector = '0;
    out_ready = 0; flush = 0; reset = 1;
    @(posedge clk);
    #1;
    model_clear();

    // Reset, then DEPTH=2 streaming
    drive(0, 0, 0, 0, 1, 0, 1); tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    check("reset in_ready", ir2, 1'b1);
    check("reset out_valid", ov2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h11 * (i + 1), 4'(i + 1), 0, 1, 0, 0);
      if (i == 1) check("stream d2 not yet valid", ov2, 1'b0);
      if (i >= 2) begin
        check("stream d2 head data", od2, 32'h11 * (i - 1));
        check("stream d2 head idx", oi2, 4'(i - 1));
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 1, 0, 0); tick(); end

    // Backpressure on a full DEPTH=3 chain
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    drive(1, 32'hA, 1, 0, 0, 0, 0); tick();
    drive(1, 32'hB, 2, 0, 0, 0, 0); tick();
    drive(1, 32'hC, 3, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hD, 4, 0, 0, 0, 0);
      check("bp d3 in_ready low", ir3, 1'b0);
      check("bp d3 occupancy", occ3, 2'd3);
      check("bp d3 head held", od3, 32'hA);
      tick();
    end
    drive(1, 32'hD, 4, 0, 1, 0, 0);
    check("bp d3 enq+deq ready", ir3, 1'b1);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    check("bp d3 occupancy stays full", occ3, 2'd3);
    check("bp d3 next head", od3, 32'hB);
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 1, 0, 0); tick(); end

    // Bubble collapse behind a stalled head
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    drive(1, 32'h5, 9, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick(); tick();
    check("bubble d3 head valid", ov3, 1'b1);
    check("bubble d3 head data", od3, 32'h5);
    check("bubble d3 occupancy", occ3, 2'd1);
    check("bubble d3 in_ready", ir3, 1'b1);
    tick();

    // Flush with entries in flight
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    for (int i = 0; i < 3; i++) begin drive(1, 32'h100 + i, 4'(i), 0, 0, 0, 0); tick(); end
    drive(1, 32'hF1, 15, 7, 1, 1, 0);
    check("flush in_ready", ir3, 1'b0);
    check("flush out_valid", ov3, 1'b0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    check("post-flush occupancy", occ3, 2'd0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      check("post-flush no output", ov3, 1'b0);
      tick();
    end

    // Exception vector passthrough
    drive(1, 32'h1234_5678, 7, 3'b101, 1, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin drive(0, 0, 0, 0, 1, 0, 0); tick(); end
    check("exc d3 idx", oi3, 4'd7);
    check("exc d3 vector", oe3, 3'b101);
    check("exc d3 data", od3, 32'h1234_5678);

    // Reset mid-stream
    drive(1, 32'h77, 3, 2, 0, 0, 0); tick();
    drive(1, 32'h88, 4, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("mid d3 occupancy before reset", occ3, 2'd2);
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("mid reset out_valid", ov3, 1'b0);
    check("mid reset data", od3, 32'h0);
    check("mid reset idx", oi3, 4'h0);
    check("mid reset exc", oe3, 3'h0);
    check("mid reset occupancy", occ3, 2'd0);
    check("mid reset in_ready", ir3, 1'b1);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(99) < 70, $urandom, 4'($urandom), 3'($urandom),
            $urandom_range(99) < 55, $urandom_range(99) < 3, $urandom_range(199) < 1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
